// File: rtl/lstm_hidden_gate_pkg.sv
// Shared LSTM defines: Q8.8 width, product rounding constant and the hidden-output packet.
package lstm_hidden_gate_pkg;

  localparam int unsigned LSTM_INPUT_BITS = 16;
  localparam int unsigned LSTM_PROD_BITS  = 2 * LSTM_INPUT_BITS;

  // Half an LSB of Q8.8 in the Q16.16 product domain.
  localparam logic signed [LSTM_PROD_BITS-1:0] LSTM_ROUND_CONST = 32'sh0000_0080;

  typedef struct packed {
    logic [LSTM_INPUT_BITS-1:0] data;
    logic                       last;
  } HIDDEN_OUTPUT_PACKET;

endpackage

// File: rtl/og_fifo.sv
// Output-gate FIFO: power-of-two depth, synchronous clear, full/empty flags, show-ahead head.
module og_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == (PW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !clear) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/lstm_hidden_gate.sv
// LSTM hidden gate h_t = o_t * tanh(c_t), Q8.8, 2-cycle pipeline with o_t FIFO.
// Define LSTM_HIDDEN_SAT_EN to saturate instead of wrapping the rounded result.
module lstm_hidden_gate
  import lstm_hidden_gate_pkg::*;
#(
  parameter int unsigned OG_DEPTH = 4,
  parameter int unsigned VEC_LEN  = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        o_valid,
  input  logic [15:0] o_data,
  output logic        o_ready,
  input  logic        t_valid,
  input  logic [15:0] t_data,
  output logic        h_valid,
  output logic [15:0] h_data,
  output logic        h_last,
  output logic        err_underflow
);

  localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  logic [LSTM_INPUT_BITS-1:0]       w_fifo_head;
  logic                             w_fifo_full;
  logic                             w_fifo_empty;
  logic                             w_pair;
  logic                             w_pop;
  logic                             w_bypass;
  logic                             w_push;
  logic                             w_underflow;
  logic [LSTM_INPUT_BITS-1:0]       w_o_sel;
  logic signed [LSTM_PROD_BITS-1:0] w_prod;
  logic signed [LSTM_PROD_BITS-1:0] w_round;
  logic [LSTM_INPUT_BITS-1:0]       w_h_data;
  logic                             w_last;

  logic                             r_p1_valid;
  logic signed [LSTM_PROD_BITS-1:0] r_prod;
  logic                             r_h_valid;
  HIDDEN_OUTPUT_PACKET              r_h_pkt;
  logic [CNT_W-1:0]                 r_cnt;
  logic                             r_err;

  assign w_pair      = t_valid && (!w_fifo_empty || o_valid);
  assign w_pop       = t_valid && !w_fifo_empty;
  // Empty FIFO plus same-cycle o_valid pairs directly and must not also enqueue.
  assign w_bypass    = t_valid && w_fifo_empty && o_valid;
  assign w_push      = o_valid && !w_fifo_full && !w_bypass;
  assign w_underflow = t_valid && w_fifo_empty && !o_valid;
  assign w_o_sel     = w_fifo_empty ? o_data : w_fifo_head;
  assign w_prod      = $signed(w_o_sel) * $signed(t_data);
  assign w_round     = r_prod + LSTM_ROUND_CONST;
  assign w_last      = (r_cnt == CNT_W'(VEC_LEN - 1));

  og_fifo #(
    .DEPTH (OG_DEPTH),
    .WIDTH (LSTM_INPUT_BITS)
  ) u_og_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (clear),
    .i_push      (w_push),
    .i_push_data (o_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

`ifdef LSTM_HIDDEN_SAT_EN
  logic signed [LSTM_PROD_BITS-1:0] w_shift;
  assign w_shift = w_round >>> 8;

  always_comb begin
    w_h_data = w_shift[LSTM_INPUT_BITS-1:0];
    if (w_shift > 32'sh0000_7FFF)       w_h_data = 16'h7FFF;
    else if (w_shift < -32'sh0000_8000) w_h_data = 16'h8000;
  end
`else
  logic w_unused;
  assign w_h_data = w_round[23:8];
  assign w_unused = ^{w_round[31:24], w_round[7:0]};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_p1_valid <= 1'b0;
      r_prod     <= '0;
      r_h_valid  <= 1'b0;
      r_h_pkt    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else if (clear) begin
      r_p1_valid   <= 1'b0;
      r_h_valid    <= 1'b0;
      r_h_pkt.last <= 1'b0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_p1_valid <= w_pair;
      if (w_pair) r_prod <= w_prod;
      r_h_valid <= r_p1_valid;
      if (r_p1_valid) begin
        r_h_pkt.data <= w_h_data;
        r_h_pkt.last <= w_last;
        r_cnt        <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_underflow) r_err <= 1'b1;
    end
  end

  assign o_ready       = !w_fifo_full;
  assign h_valid       = r_h_valid;
  assign h_data        = r_h_pkt.data;
  assign h_last        = r_h_valid && r_h_pkt.last;
  assign err_underflow = r_err;

endmodule

// File: doc/lstm_hidden_gate.md
LSTM_HIDDEN_GATE -- requirements
Module: lstm_hidden_gate

Interface
REQ-001 Parameter OG_DEPTH, default 4, SHALL set the output-gate FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter VEC_LEN, default 64, SHALL set the hidden-vector length in elements (1..1024).
REQ-003 clock  input  1  single clock for all state, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous flush of FIFO, pipeline, counter and error flags.
REQ-006 o_valid  input  1  output-gate value o_t offered.
REQ-007 o_data  input  16  o_t, signed Q8.8.
REQ-008 o_ready  output  1  FIFO can accept o_data this cycle.
REQ-009 t_valid  input  1  tanh(c_t) result present; tanh stage has no backpressure.
REQ-010 t_data  input  16  tanh(c_t), signed Q8.8.
REQ-011 h_valid  output  1  h_data/h_last valid this cycle.
REQ-012 h_data  output  16  h_t = o_t * tanh(c_t), signed Q8.8.
REQ-013 h_last  output  1  h_data is element VEC_LEN-1 of the vector.
REQ-014 err_underflow  output  1  sticky: t_valid arrived with no o_t available.

Function
REQ-015 o_ready SHALL equal "FIFO not full"; a push SHALL occur when o_valid && o_ready.
REQ-016 A pair SHALL form on t_valid when the FIFO is non-empty (pops head) or, when empty, with same-cycle o_valid (bypass, no push).
REQ-017 t_valid with FIFO empty and o_valid low SHALL drop t_data, set err_underflow, produce no output and not advance the counter.
REQ-018 Push and pop in one cycle SHALL keep occupancy unchanged; FIFO pointers SHALL wrap modulo OG_DEPTH.
REQ-019 Stage 1 SHALL register the 32-bit signed product o*t; stage 2 SHALL compute (p + 0x80) >>> 8 and register h_data.
REQ-020 Latency SHALL be exactly 2 cycles: paired t_valid at edge N gives h_valid high for one cycle after edge N+2; throughput 1 per cycle.
REQ-021 An element counter SHALL increment on every h_valid, assert h_last when it equals VEC_LEN-1, then wrap to 0.
REQ-022 clear SHALL take priority over same-cycle push, pair and output: FIFO empty, pipeline valids 0, counter 0, err_underflow 0.

Reset
REQ-023 reset_n low SHALL immediately force: o_ready 1 (FIFO empty), h_valid 0, h_data 0x0000, h_last 0, err_underflow 0, counter 0, pipeline valids 0.
REQ-024 Reset mid-operation SHALL discard all in-flight pairs; no h_valid SHALL appear for pre-reset data.

Configuration
REQ-025 With LSTM_HIDDEN_SAT_EN defined, stage 2 SHALL saturate the shifted result to [0x8000, 0x7FFF].
REQ-026 Without LSTM_HIDDEN_SAT_EN, stage 2 SHALL take bits [23:8] of the rounded product (two's-complement wrap).

Structure
REQ-027 Q8.8 width (LSTM_INPUT_BITS), rounding constant and HIDDEN_OUTPUT_PACKET typedef (data, last) SHALL live in the shared LSTM defines package.
REQ-028 The FIFO SHALL be sub-module og_fifo (parameter DEPTH, push/pop/full/empty/clear); multiply and rounding SHALL stay in lstm_hidden_gate.

Verification
REQ-029 o=0x0080, t=0x0080 -> h_data=0x0040 two cycles after t_valid.
REQ-030 o=0x0100, t=0xFF00 -> h_data=0xFF00; o=0x0000, any t -> 0x0000.
REQ-031 o=0x7FFF, t=0x7FFF -> 0x7FFF with LSTM_HIDDEN_SAT_EN, 0xFF00 without.
REQ-032 Push 4 o's with no t (OG_DEPTH=4) -> o_ready low after 4th push; one t_valid -> o_ready high the next cycle.
REQ-033 t_valid with empty FIFO, o_valid low -> no h_valid, err_underflow=1 until clear.
REQ-034 VEC_LEN=4, 9 paired inputs -> h_last on outputs 4 and 8 only; reset_n pulse with 2 pairs in flight -> zero outputs, counter 0.
